// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and parity helper.
// The receive path imports this package as well.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;

    // Odd parity: the returned bit makes the total count of ones in byte plus parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 line plus a one-cycle falling-edge strobe.
// The flops reset to 1 because both PS/2 lines idle high.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // NOTE: non-blocking assignments make each stage capture the previous stage's old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, LSB-first byte, odd parity,
// stop, ack check and a transaction timeout. All bus controls and status are registered.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic data_fall_unused;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_clk_in),
        .sync_o (clk_sync),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2_data_in),
        .sync_o (data_sync),
        .fall_o (data_fall_unused)
    );

    ps2_tx_state_e state_q;
    logic [7:0]    tx_q;
    logic          par_q;
    logic [3:0]    bit_q;
    logic [IW-1:0] inh_cnt_q;
    logic [TW-1:0] to_cnt_q;
    logic          clk_oe_q;
    logic          data_oe_q;
    logic          busy_q;
    logic          done_q;
    logic          ack_err_q;

    logic active;
    assign active = (state_q == RTS) || (state_q == SEND) ||
                    (state_q == ACK) || (state_q == WAIT_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            par_q     <= 1'b0;
            bit_q     <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (active && to_cnt_q == TO_LAST) begin
                clk_oe_q  <= 1'b0;
                data_oe_q <= 1'b0;
                ack_err_q <= 1'b1;
                done_q    <= 1'b1;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
            end else begin
                if (active) begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        // A send in the done cycle is dropped so it cannot chain onto the old frame.
                        if (send && !done_q) begin
                            tx_q      <= tx_data;
                            par_q     <= odd_parity(tx_data);
                            ack_err_q <= 1'b0;
                            busy_q    <= 1'b1;
                            clk_oe_q  <= 1'b1;
                            inh_cnt_q <= '0;
                            state_q   <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (inh_cnt_q == INH_LAST) begin
                            clk_oe_q <= 1'b0;
                            bit_q    <= '0;
                            to_cnt_q <= '0;
                            state_q  <= RTS;
                        end else begin
                            if (inh_cnt_q == INH_START) begin
                                data_oe_q <= 1'b1;
                            end
                            inh_cnt_q <= inh_cnt_q + 1'b1;
                        end
                    end
                    RTS, SEND: begin
                        if (clk_fall) begin
                            if (bit_q < 4'd8) begin
                                data_oe_q <= ~tx_q[bit_q[2:0]];
                            end else if (bit_q == 4'd8) begin
                                data_oe_q <= ~par_q;
                            end else begin
                                data_oe_q <= 1'b0;
                            end
                            bit_q   <= bit_q + 1'b1;
                            state_q <= (bit_q == 4'd9) ? ACK : SEND;
                        end
                    end
                    ACK: begin
                        if (clk_fall) begin
                            ack_err_q <= data_sync;
                            state_q   <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;

endmodule
